k2_exec_ctrl: RTL

//  Execution controller for the K2 8-bit core. Gates core advance via a clock-enable and holds
//  the core in reset while idle. Provides run / stop / single-step, a PC breakpoint and

---
 rtl/k2_exec_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/k2_exec_ctrl.sv
// k2_exec_ctrl: run/stop/step execution controller for the K2 8-bit core.
// Gates core advance with a clock-enable, holds the core in reset while idle,
// halts on a PC breakpoint or a jump-to-self, and counts retired instructions.
module k2_exec_ctrl #(
    parameter int PC_BITS  = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                step,
    input  logic                clear,
    input  logic                bp_en,
    input  logic [PC_BITS-1:0]  bp_addr,
    input  logic [PC_BITS-1:0]  pc,
    output logic                core_en,
    output logic                core_rst,
    output logic [1:0]          state,
    output logic [1:0]          halt_cause,
    output logic [CNT_BITS-1:0] retired
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_STOP = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_LOOP = 2'b11;

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
    localparam logic [CNT_BITS-1:0] CNT_ZERO = {CNT_BITS{1'b0}};

    state_t              state_q, state_d;
    logic [1:0]          cause_q, cause_d;
    logic [CNT_BITS-1:0] retired_q, retired_d;
    logic                bp_skip_q, bp_skip_d;
    logic                last_en_q;
    logic [PC_BITS-1:0]  last_pc_q;

    logic bp_hit_s;
    logic loop_hit_s;
    logic core_en_s;

    // Halt conditions and the core advance enable.
    always_comb begin
        bp_hit_s   = bp_en & (pc == bp_addr) & ~bp_skip_q;
        // A wrap from the top PC back to 0 changes the PC, so it never matches here.
        loop_hit_s = last_en_q & (pc == last_pc_q);
        core_en_s  = ((state_q == ST_RUN) & ~bp_hit_s & ~loop_hit_s)
                   | (state_q == ST_STEP);
    end

    // Next-state, halt cause and breakpoint-skip logic. Commands are resolved by
    // priority first (stop > step > start > clear); a winning command that has no
    // meaning in the current state leaves the controller unchanged.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        bp_skip_d = bp_skip_q;
        case (state_q)
            ST_IDLE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (step) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_NONE;
                end else if (start) begin
                    state_d   = ST_RUN;
                    bp_skip_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // The resume skip covers only the first instruction actually executed.
                if (core_en_s) begin
                    bp_skip_d = 1'b0;
                end else begin
                    bp_skip_d = bp_skip_q;
                end
                if (stop) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_STOP;
                end else if (bp_hit_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                end else if (loop_hit_s) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_LOOP;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
                cause_d = CAUSE_NONE;
            end
            ST_HALT: begin
                if (stop) begin
                    state_d = ST_HALT;
                end else if (step) begin
                    state_d = ST_STEP;
                    cause_d = CAUSE_NONE;
                end else if (start) begin
                    state_d   = ST_RUN;
                    cause_d   = CAUSE_NONE;
                    bp_skip_d = 1'b1;
                end else if (clear) begin
                    state_d = ST_IDLE;
                    cause_d = CAUSE_NONE;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cause_d   = CAUSE_NONE;
                bp_skip_d = 1'b0;
            end
        endcase
    end

    // Retired-instruction counter: zero in IDLE, saturating increment on each executed instruction.
    always_comb begin
        if (state_d == ST_IDLE) begin
            retired_d = CNT_ZERO;
        end else if (core_en_s && (retired_q != CNT_MAX)) begin
            retired_d = retired_q + CNT_ONE;
        end else begin
            retired_d = retired_q;
        end
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            retired_q <= CNT_ZERO;
            bp_skip_q <= 1'b0;
            last_en_q <= 1'b0;
            last_pc_q <= {PC_BITS{1'b0}};
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
            bp_skip_q <= bp_skip_d;
            last_en_q <= core_en_s;
            last_pc_q <= pc;
        end
    end

    assign core_en    = core_en_s;
    assign core_rst   = (state_q == ST_IDLE);
    assign state      = state_q;
    assign halt_cause = cause_q;
    assign retired    = retired_q;

endmodule
